gcd_control_fsm: RTL and testbench
==================================

// Module: gcd_control_fsm
// PURPOSE
//  Control unit for the 16-bit subtractive GCD datapath. Drives its load, clear and mux selects, and consumes its lt/gt/eq compare flags.
//  Fetches operand A then B from the shared data_in bus via a valid/ready handshake. Iterates
//  larger-minus-smaller until eq. Signals done (result held in datapath register A) or err (timeout / bad flags).
// PARAMETERS
//  ITER_W    17     width of iteration counter
//  MAX_ITER  65535  max subtract iterations before abort (covers gcd(65535,1)=65534)
// PORTS
//  clock     in   1  single clock, all state on rising edge
//  reset     in   1  synchronous, active-high
//  start     in   1  request new GCD; sampled in IDLE/ERR only
//  in_valid  in   1  operand present on datapath data_in
//  in_ready  out  1  controller accepting operand (LOAD_A/LOAD_B)
//  lt,gt,eq  in   1  datapath compare flags (A<B, A>B, A==B), combinational from A/B regs
//  loada     out  1  load datapath reg A from bus
//  loadb     out  1  load datapath reg B from bus
//  loadp     out  1  capture subtractor result P = X - Y
//  clearp    out  1  clear subtractor result register
//  sel1      out  1  X mux: 0=A, 1=B
//  sel2      out  1  Y mux: 0=A, 1=B
//  selb      out  1  bus mux: 0=data_in, 1=P
//  busy      out  1  high from operand fetch through last iteration
//  done      out  1  one-cycle pulse: result valid in reg A
//  err       out  1  held high in ERR until next start or reset
// BEHAVIOUR
//  - Outputs decoded from state (in_ready-gated loads Mealy); defaults 0. Reset -> IDLE, iter=0.
//    Post-reset outputs: clearp=1, all others 0.
//  - IDLE: clearp=1. start -> LOAD_A, iter<=0.
//  - LOAD_A: in_ready=1, selb=0, busy=1. in_valid -> loada=1 same cycle, -> LOAD_B.
//  - LOAD_B: in_ready=1, selb=0, busy=1. in_valid -> loadb=1 same cycle, -> CMP.
//  - CMP: busy=1. Flags must be one-hot: eq -> DONE; gt -> SUB_A; lt -> SUB_B; else -> ERR.
//  - SUB_A: sel1=0, sel2=1, loadp=1 (P=A-B), iter++. SUB_B: sel1=1, sel2=0, loadp=1 (P=B-A), iter++.
//    Either with iter==MAX_ITER -> ERR, no loadp.
//  - WR_A: selb=1, loada=1 -> CMP. WR_B: selb=1, loadb=1 -> CMP.
//  - DONE: done=1 one cycle, busy=0 -> IDLE. ERR: err=1. start -> LOAD_A, err clears that cycle.
//  - Timing: start accept -> LOAD_A next cycle.
//    Operands with in_valid held high: CMP 3 cycles after start.
//    Each iteration: 3 cycles (SUB, WR, CMP). done = 3 + 3*N + 1 cycles after start, N subtractions.
//  - start outside IDLE/ERR ignored. in_valid outside LOAD_A/B ignored, in_ready=0.
//  - Zero operand never reaches eq (A-0 loops): must end in ERR via MAX_ITER.
//  - Reset mid-operation: next cycle IDLE, busy/done/err=0, clearp=1. Datapath regs not cleared.
//  - Iteration counter saturates at MAX_ITER, never wraps.
// STRUCTURE
//  - gcd_pkg: state encoding localparams, SEL_A=0/SEL_B=1, BUS_DIN=0/BUS_SUB=1, default MAX_ITER.
//  - Sub-module gcd_iter_counter (clear, inc, saturate, at_max flag). Rest is one FSM, no datapath logic.
//  - Top-level gcd_top instantiates gcd_control_fsm + datapath; benches below run against gcd_top.
// TESTING
//  1. A=48,B=18: 4 subtractions (30,12 then B:6 then A:6), done at cycle 3+12+1=16 after start, A reg=6, err=0.
//  2. A=7,B=7: CMP sees eq, done 4 cycles after start, no loadp ever asserted.
//  3. A=0,B=5, MAX_ITER=8: 8 SUB_B iterations then ERR, err held, busy=0. Next start clears err.
//  4. in_valid low 5 cycles in LOAD_B: loadb not asserted, in_ready stays 1. Then completes normally.
//  5. Reset asserted in WR_A of A=48,B=18 run: next cycle IDLE, loada=0, clearp=1, done never pulses. New start works.
//  6. Force lt=gt=1 in CMP -> ERR. start pulsed during busy -> ignored, run unaffected.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the subtractive GCD controller: state encoding,
// mux select encodings and default iteration limits.
package gcd_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD_A = 4'd1,
        S_LOAD_B = 4'd2,
        S_CMP    = 4'd3,
        S_SUB_A  = 4'd4,
        S_SUB_B  = 4'd5,
        S_WR_A   = 4'd6,
        S_WR_B   = 4'd7,
        S_DONE   = 4'd8,
        S_ERR    = 4'd9
    } state_t;

    localparam logic SEL_A   = 1'b0;
    localparam logic SEL_B   = 1'b1;
    localparam logic BUS_DIN = 1'b0;
    localparam logic BUS_SUB = 1'b1;

    localparam int DEFAULT_ITER_W   = 17;
    localparam int DEFAULT_MAX_ITER = 65535;

endpackage

// File: rtl/gcd_iter_counter.sv
// Subtraction iteration counter: synchronous clear, increment, saturates at
// MAX_ITER and flags when the limit is reached.
module gcd_iter_counter #(
    parameter int ITER_W   = 17,
    parameter int MAX_ITER = 65535
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic at_max
);

    localparam logic [ITER_W-1:0] MAX_VAL = ITER_W'(MAX_ITER);

    logic [ITER_W-1:0] count_q;
    logic [ITER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != MAX_VAL)) begin
            count_d = count_q + ITER_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_max = (count_q == MAX_VAL);

endmodule

// File: rtl/gcd_control_fsm.sv
// Control FSM for the 16-bit subtractive GCD datapath: fetches A and B over a
// valid/ready bus, subtracts larger-minus-smaller until equal, reports done/err.
module gcd_control_fsm
    import gcd_pkg::*;
#(
    parameter int ITER_W   = DEFAULT_ITER_W,
    parameter int MAX_ITER = DEFAULT_MAX_ITER
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic in_valid,
    output logic in_ready,
    input  logic lt,
    input  logic gt,
    input  logic eq,
    output logic loada,
    output logic loadb,
    output logic loadp,
    output logic clearp,
    output logic sel1,
    output logic sel2,
    output logic selb,
    output logic busy,
    output logic done,
    output logic err
);

    state_t state_q;
    state_t state_d;
    logic   iter_clear;
    logic   iter_inc;
    logic   iter_at_max;

    gcd_iter_counter #(
        .ITER_W  (ITER_W),
        .MAX_ITER(MAX_ITER)
    ) u_iter (
        .clock (clock),
        .reset (reset),
        .clear (iter_clear),
        .inc   (iter_inc),
        .at_max(iter_at_max)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        iter_clear = 1'b0;
        iter_inc   = 1'b0;
        in_ready   = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadp      = 1'b0;
        clearp     = 1'b0;
        sel1       = SEL_A;
        sel2       = SEL_A;
        selb       = BUS_DIN;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state_q)
            S_IDLE: begin
                clearp = 1'b1;
                if (start) begin
                    iter_clear = 1'b1;
                    state_d    = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    loada   = 1'b1;
                    state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    loadb   = 1'b1;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                busy = 1'b1;
                // Anything other than exactly one flag means a broken datapath.
                case ({lt, gt, eq})
                    3'b001:  state_d = S_DONE;
                    3'b010:  state_d = S_SUB_A;
                    3'b100:  state_d = S_SUB_B;
                    default: state_d = S_ERR;
                endcase
            end
            S_SUB_A: begin
                busy = 1'b1;
                sel1 = SEL_A;
                sel2 = SEL_B;
                if (iter_at_max) begin
                    state_d = S_ERR;
                end else begin
                    loadp    = 1'b1;
                    iter_inc = 1'b1;
                    state_d  = S_WR_A;
                end
            end
            S_SUB_B: begin
                busy = 1'b1;
                sel1 = SEL_B;
                sel2 = SEL_A;
                if (iter_at_max) begin
                    state_d = S_ERR;
                end else begin
                    loadp    = 1'b1;
                    iter_inc = 1'b1;
                    state_d  = S_WR_B;
                end
            end
            S_WR_A: begin
                busy    = 1'b1;
                selb    = BUS_SUB;
                loada   = 1'b1;
                state_d = S_CMP;
            end
            S_WR_B: begin
                busy    = 1'b1;
                selb    = BUS_SUB;
                loadb   = 1'b1;
                state_d = S_CMP;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                // err drops in the same cycle a restart is accepted.
                err = ~start;
                if (start) begin
                    iter_clear = 1'b1;
                    state_d    = S_LOAD_A;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gcd_control_fsm.sv
// Bench for gcd_control_fsm with a behavioural GCD datapath and a scoreboard
// of expected completions (result, latency, subtraction count, done vs err).
module tb_gcd_control_fsm;

    localparam int MAX_IT = 8;

    logic clk = 1'b0;
    logic reset, start, in_valid, in_ready, lt, gt, eq;
    logic loada, loadb, loadp, clearp, sel1, sel2, selb, busy, done, err;

    logic [15:0] a_reg = '0, b_reg = '0, p_reg = '0, data_in = '0;
    logic        force_bad = 1'b0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gcd_control_fsm #(.ITER_W(17), .MAX_ITER(MAX_IT)) dut (
        .clock(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .lt(lt), .gt(gt), .eq(eq),
        .loada(loada), .loadb(loadb), .loadp(loadp), .clearp(clearp),
        .sel1(sel1), .sel2(sel2), .selb(selb),
        .busy(busy), .done(done), .err(err)
    );

    // Behavioural datapath
    wire [15:0] x_mux = sel1 ? b_reg : a_reg;
    wire [15:0] y_mux = sel2 ? b_reg : a_reg;
    wire [15:0] bus   = selb ? p_reg : data_in;
    assign lt = force_bad | (a_reg < b_reg);
    assign gt = force_bad | (a_reg > b_reg);
    assign eq = ~force_bad & (a_reg == b_reg);

    always @(posedge clk) begin
        if (loada) a_reg <= bus;
        if (loadb) b_reg <= bus;
        if (clearp) p_reg <= '0;
        else if (loadp) p_reg <= x_mux - y_mux;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          is_err;
        logic [15:0] exp_a;
        int          exp_cyc;
        int          exp_n;
        int          st;
    } exp_t;

    exp_t sb_q[$];
    int   loadp_cnt = 0;
    int   n_end = 0;
    logic err_prev = 1'b0;
    logic done_prev = 1'b0;

    // Completion monitor: pops the scoreboard on every done pulse or err rise.
    always @(negedge clk) begin
        if (!reset) begin
            if (loadp) loadp_cnt++;
            if (done_prev) check("done_one_cycle", int'(done), 0);
            if (done || (err && !err_prev)) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_completion", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("completion: kind=%s latency=%0d subs=%0d a_reg=%0d",
                             err ? "err" : "done", cyc - e.st, loadp_cnt, a_reg);
                    check("kind_err", int'(err), int'(e.is_err));
                    check("latency", cyc - e.st, e.exp_cyc);
                    check("subtractions", loadp_cnt, e.exp_n);
                    check("busy_at_end", int'(busy), 0);
                    if (!e.is_err) check("result_a", int'(a_reg), int'(e.exp_a));
                end
                n_end++;
            end
        end
        err_prev  = err;
        done_prev = done;
    end

    typedef struct {
        logic [15:0] a, b, exp_a;
        bit          exp_err;
        int          exp_cyc, exp_n, gap, spur;
        bit          bad;
    } vec_t;

    task automatic run_vec(input vec_t v);
        logic prev_err;
        int   st;
        int   n0;
        @(negedge clk);
        prev_err  = err;
        start     = 1'b1;
        force_bad = v.bad;
        st        = cyc;
        loadp_cnt = 0;
        n0        = n_end;
        sb_q.push_back('{v.exp_err, v.exp_a, v.exp_cyc, v.exp_n, st});
        #1;
        if (prev_err) check("err_clears_on_start", int'(err), 0);
        @(negedge clk);
        start    = 1'b0;
        data_in  = v.a;
        in_valid = 1'b1;
        #1;
        check("in_ready_load_a", int'(in_ready), 1);
        check("loada_on_valid", int'(loada), 1);
        @(negedge clk);
        for (int i = 0; i < v.gap; i++) begin
            in_valid = 1'b0;
            data_in  = 16'hBEEF;
            #1;
            check("loadb_held_off", int'(loadb), 0);
            check("in_ready_wait_b", int'(in_ready), 1);
            @(negedge clk);
        end
        data_in  = v.b;
        in_valid = 1'b1;
        #1;
        check("loadb_on_valid", int'(loadb), 1);
        @(negedge clk);
        data_in = 16'hDEAD;
        for (int i = 0; i < 200 && n_end == n0; i++) begin
            start = ((cyc - st) == v.spur) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        if (n_end == n0) check("completion_timeout", 0, 1);
        force_bad = 1'b0;
        if (v.exp_err) begin
            repeat (3) @(negedge clk);
            check("err_held", int'(err), 1);
            check("busy_in_err", int'(busy), 0);
        end
    endtask

    vec_t vecs[9];

    initial begin
        //               a   b   exp_a err cyc n gap spur bad
        vecs[0] = '{16'd48, 16'd18, 16'd6, 1'b0, 16, 4, 0, -1, 1'b0};
        vecs[1] = '{16'd7,  16'd7,  16'd7, 1'b0,  4, 0, 0, -1, 1'b0};
        vecs[2] = '{16'd0,  16'd5,  16'd0, 1'b1, 29, 8, 0, -1, 1'b0};
        vecs[3] = '{16'd12, 16'd8,  16'd4, 1'b0, 10, 2, 0, -1, 1'b0};
        vecs[4] = '{16'd48, 16'd18, 16'd6, 1'b0, 21, 4, 5, -1, 1'b0};
        vecs[5] = '{16'd9,  16'd1,  16'd1, 1'b0, 28, 8, 0, -1, 1'b0};
        vecs[6] = '{16'd10, 16'd1,  16'd0, 1'b1, 29, 8, 0, -1, 1'b0};
        vecs[7] = '{16'd7,  16'd3,  16'd0, 1'b1,  4, 0, 0, -1, 1'b1};
        vecs[8] = '{16'd48, 16'd18, 16'd6, 1'b0, 16, 4, 0,  8, 1'b0};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_clearp", int'(clearp), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_loads", int'({loada, loadb, loadp}), 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            $display("vector %0d: a=%0d b=%0d", i, vecs[i].a, vecs[i].b);
            run_vec(vecs[i]);
        end

        // Reset in WR_A of a 48/18 run: controller must abandon it cleanly.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; data_in = 16'd48; in_valid = 1'b1;
        @(negedge clk);
        data_in = 16'd18;
        @(negedge clk);
        data_in = 16'hDEAD;
        repeat (2) @(negedge clk);
        #1;
        check("wr_a_loada", int'(loada), 1);
        check("wr_a_selb", int'(selb), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_loada", int'(loada), 0);
        check("midrst_clearp", int'(clearp), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done_err", int'({done, err}), 0);
        $display("reset mid-run applied at cycle %0d", cyc);
        repeat (30) @(negedge clk);

        $display("vector post-reset: a=48 b=18");
        run_vec(vecs[0]);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
